// File: rtl/conv_row_feeder_if.sv
// Pixel stream in, vertically aligned 3-row column taps out.
// Shared by conv_row_feeder and whatever drives it.
interface conv_row_feeder_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CW          = 10
);
    logic [CW-1:0]          line_width;
    logic                   in_valid;
    logic                   in_sof;
    logic [PIXEL_WIDTH-1:0] in_pix;
    logic                   out_valid;
    logic                   out_eol;
    logic [PIXEL_WIDTH-1:0] pix_top;
    logic [PIXEL_WIDTH-1:0] pix_mid;
    logic [PIXEL_WIDTH-1:0] pix_bot;
    logic [CW-1:0]          out_col;

    modport master (
        output line_width, in_valid, in_sof, in_pix,
        input  out_valid, out_eol, pix_top, pix_mid, pix_bot, out_col
    );

    modport slave (
        input  line_width, in_valid, in_sof, in_pix,
        output out_valid, out_eol, pix_top, pix_mid, pix_bot, out_col
    );
endinterface

// File: rtl/conv_row_feeder.sv
// 3x3 convolution row-tap feeder: two line buffers give rows r-2, r-1, r.
// Optional top-edge replication enabled by defining BORDER_REPLICATE_EN.
module conv_row_feeder #(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_WIDTH   = 640,
    parameter int CW          = 10
) (
    input logic             clk,
    input logic             rst,
    conv_row_feeder_if.slave io
);
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [CW-1:0] WMAX = CW'(MAX_WIDTH);
    localparam logic [CW-1:0] RMAX = '1;

    logic [PIXEL_WIDTH-1:0] lb_a [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb_b [MAX_WIDTH];

    logic [CW-1:0] col, row, width;
    logic [CW-1:0] cur_col, cur_row, cur_width, lw_clamp;
    logic [AW-1:0] addr;
    logic [PIXEL_WIDTH-1:0] a_old, b_old, top_n, mid_n;
    logic eol, vld_n;

    // An accepted sof restarts the frame on the very pixel that carries it.
    always_comb begin
        lw_clamp = io.line_width;
        if (io.line_width == '0 || io.line_width > WMAX)
            lw_clamp = WMAX;
        cur_col   = col;
        cur_row   = row;
        cur_width = width;
        if (io.in_sof) begin
            cur_col   = '0;
            cur_row   = '0;
            cur_width = lw_clamp;
        end
        addr  = cur_col[AW-1:0];
        a_old = lb_a[addr];
        b_old = lb_b[addr];
        eol   = (cur_col == cur_width - CW'(1));
`ifdef BORDER_REPLICATE_EN
        vld_n = 1'b1;
        top_n = b_old;
        mid_n = a_old;
        if (cur_row == '0) begin
            top_n = io.in_pix;
            mid_n = io.in_pix;
        end else if (cur_row == CW'(1)) begin
            top_n = a_old;
        end
`else
        vld_n = (cur_row >= CW'(2));
        top_n = b_old;
        mid_n = a_old;
`endif
    end

    // Read-before-write: B takes A's old row, A takes the new pixel.
    always_ff @(posedge clk) begin
        if (!rst && io.in_valid) begin
            lb_a[addr] <= io.in_pix;
            lb_b[addr] <= a_old;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            width        <= WMAX;
            io.out_valid <= 1'b0;
            io.out_eol   <= 1'b0;
            io.pix_top   <= '0;
            io.pix_mid   <= '0;
            io.pix_bot   <= '0;
            io.out_col   <= '0;
        end else if (io.in_valid) begin
            col          <= eol ? '0 : cur_col + CW'(1);
            if (eol && cur_row != RMAX)
                row <= cur_row + CW'(1);
            else
                row <= cur_row;
            width        <= cur_width;
            io.out_valid <= vld_n;
            io.out_eol   <= eol;
            io.pix_top   <= top_n;
            io.pix_mid   <= mid_n;
            io.pix_bot   <= io.in_pix;
            io.out_col   <= cur_col;
        end else begin
            io.out_valid <= 1'b0;
            io.out_eol   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_row_feeder.sv
// Directed bench for conv_row_feeder (MAX_WIDTH=8, CW=4).
// Expectations follow the BORDER_REPLICATE_EN setting of the build.
module tb_conv_row_feeder;
    localparam int PW = 8;
    localparam int MW = 8;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    conv_row_feeder_if #(.PIXEL_WIDTH(PW), .CW(CW)) bus ();

    conv_row_feeder #(
        .PIXEL_WIDTH(PW),
        .MAX_WIDTH  (MW),
        .CW         (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Frame pixel value = base + idx; rows/cols follow from idx and w.
    task automatic px(bit sof, int base, int idx, int w);
        int r, c, v;
        r = idx / w;
        c = idx % w;
        v = base + idx;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pix   = PW'(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        chk("bot", 32'(bus.pix_bot), 32'(v));
        chk("col", 32'(bus.out_col), 32'(c));
        chk("eol", 32'(bus.out_eol), 32'(c == w - 1));
`ifdef BORDER_REPLICATE_EN
        chk("valid", 32'(bus.out_valid), 32'd1);
        if (r == 0) begin
            chk("top", 32'(bus.pix_top), 32'(v));
            chk("mid", 32'(bus.pix_mid), 32'(v));
        end else if (r == 1) begin
            chk("top", 32'(bus.pix_top), 32'(v - w));
            chk("mid", 32'(bus.pix_mid), 32'(v - w));
        end else begin
            chk("top", 32'(bus.pix_top), 32'(v - 2 * w));
            chk("mid", 32'(bus.pix_mid), 32'(v - w));
        end
`else
        chk("valid", 32'(bus.out_valid), 32'(r >= 2));
        if (r >= 1)
            chk("mid", 32'(bus.pix_mid), 32'(v - w));
        if (r >= 2)
            chk("top", 32'(bus.pix_top), 32'(v - 2 * w));
`endif
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.line_width = CW'(4);
        bus.in_valid   = 1'b1;
        bus.in_sof     = 1'b1;
        bus.in_pix     = 8'hAA;

        // reset held with live input
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_bot", 32'(bus.pix_bot), 32'd0);
            chk("rst_top", 32'(bus.pix_top), 32'd0);
            chk("rst_mid", 32'(bus.pix_mid), 32'd0);
            chk("rst_col", 32'(bus.out_col), 32'd0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_eol", 32'(bus.out_eol), 32'd0);
        chk("rel_bot", 32'(bus.pix_bot), 32'd0);

        // contiguous frame, width 4
        bus.line_width = CW'(4);
        for (int i = 0; i < 16; i++)
            px(i == 0, 0, i, 4);

        // stalled frame; width change and lone sof in gaps are ignored
        for (int i = 0; i < 16; i++) begin
            px(i == 0, 0, i, 4);
            bus.line_width = CW'(2);
            bus.in_sof     = 1'b1;
            @(posedge clk);
            #1;
            bus.in_sof = 1'b0;
            chk("gap_valid", 32'(bus.out_valid), 32'd0);
            chk("gap_eol", 32'(bus.out_eol), 32'd0);
            chk("gap_bot", 32'(bus.pix_bot), 32'(i));
            chk("gap_col", 32'(bus.out_col), 32'(i % 4));
        end

        // mid-line sof restarts priming
        bus.line_width = CW'(4);
        for (int i = 0; i < 10; i++)
            px(i == 0, 100, i, 4);
        for (int i = 0; i < 12; i++)
            px(i == 0, 0, i, 4);

        // width 0 clamps to MAX_WIDTH
        bus.line_width = CW'(0);
        for (int i = 0; i < 16; i++)
            px(i == 0, 20, i, 8);

        // width 1: every pixel is eol
        bus.line_width = CW'(1);
        for (int i = 0; i < 5; i++)
            px(i == 0, 60, i, 1);

        // width above MAX_WIDTH clamps
        bus.line_width = CW'(9);
        for (int i = 0; i < 10; i++)
            px(i == 0, 80, i, 8);

        // reset mid-frame, then pixels without sof restart at MAX_WIDTH
        bus.line_width = CW'(3);
        for (int i = 0; i < 5; i++)
            px(i == 0, 140, i, 3);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pix   = 8'h55;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_bot", 32'(bus.pix_bot), 32'd0);
        chk("mrst_col", 32'(bus.out_col), 32'd0);
        for (int i = 0; i < 10; i++)
            px(1'b0, 50, i, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
